// File: rtl/text_clock_updater.sv
// HH:MM:SS time-of-day counter that copies its value as ASCII into one text row.
// The row is rewritten only at the start of vertical blank, and only after the time has changed.
module text_clock_updater #(
    parameter int unsigned       CLK_HZ    = 25_000_000,
    parameter int unsigned       ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              set_en,
    input  logic [7:0]        set_hh,
    input  logic [7:0]        set_mm,
    input  logic [7:0]        set_ss,
    output logic              wr_req,
    input  logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              sec_tick
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PRESC_W-1:0] presc;
    logic [7:0]         hh;
    logic [7:0]         mm;
    logic [7:0]         ss;
    logic               dirty;
    logic [2:0]         index;
    logic [7:0]         snapshot [8];
    logic               wrap;
    logic               start;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        if (v == limit)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Out-of-range fields or non-decimal nibbles load as 00.
    function automatic logic [7:0] bcd_check(input logic [7:0] v, input logic [7:0] limit);
        return (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= limit) ? v : 8'h00;
    endfunction

    function automatic logic [7:0] ascii(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    assign wrap  = (presc == PRESC_MAX);
    assign start = (state == IDLE) && frame_start && dirty;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            dirty    <= 1'b1;
            index    <= 3'd0;
            sec_tick <= 1'b0;
            for (int i = 0; i < 8; i++)
                snapshot[i] <= 8'h00;
        end else begin
            state    <= state_next;
            sec_tick <= 1'b0;

            // A load wins over a coincident wrap, so that second is dropped.
            if (set_en) begin
                hh    <= bcd_check(set_hh, 8'h23);
                mm    <= bcd_check(set_mm, 8'h59);
                ss    <= bcd_check(set_ss, 8'h59);
                presc <= '0;
            end else if (wrap) begin
                presc    <= '0;
                sec_tick <= 1'b1;
                ss       <= bcd_inc(ss, 8'h59);
                if (ss == 8'h59) begin
                    mm <= bcd_inc(mm, 8'h59);
                    if (mm == 8'h59)
                        hh <= bcd_inc(hh, 8'h23);
                end
            end else begin
                presc <= presc + PRESC_W'(1);
            end

            if (set_en || wrap)
                dirty <= 1'b1;
            else if (start)
                dirty <= 1'b0;

            // The snapshot is frozen for the whole write burst; later time changes wait for the next frame.
            if (start) begin
                snapshot[0] <= ascii(hh[7:4]);
                snapshot[1] <= ascii(hh[3:0]);
                snapshot[2] <= 8'h3A;
                snapshot[3] <= ascii(mm[7:4]);
                snapshot[4] <= ascii(mm[3:0]);
                snapshot[5] <= 8'h3A;
                snapshot[6] <= ascii(ss[7:4]);
                snapshot[7] <= ascii(ss[3:0]);
                index       <= 3'd0;
            end else if (state == WRITE && wr_gnt && index != 3'd7) begin
                index <= index + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        wr_req     = 1'b0;
        busy       = 1'b0;
        wr_addr    = BASE_ADDR;
        wr_data    = 8'h00;
        case (state)
            IDLE: begin
                if (frame_start && dirty)
                    state_next = WRITE;
            end
            WRITE: begin
                wr_req  = 1'b1;
                busy    = 1'b1;
                wr_addr = BASE_ADDR + ADDR_W'(index);
                wr_data = snapshot[index];
                if (wr_gnt && index == 3'd7)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_clock_updater.sv
// Scoreboard bench for text_clock_updater: directed sequences push expected buffer writes,
// and a negedge monitor pops and compares one entry per completed handshake.
module tb_text_clock_updater;

    localparam int          CLK_HZ = 16;
    localparam logic [10:0] BASE   = 11'h7FC;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        set_en = 1'b0;
    logic [7:0]  set_hh = 8'h00;
    logic [7:0]  set_mm = 8'h00;
    logic [7:0]  set_ss = 8'h00;
    logic        wr_gnt = 1'b1;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        sec_tick;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          grant_count = 0;
    logic [18:0] exp_q [$];
    logic [18:0] mon_exp;

    text_clock_updater #(
        .CLK_HZ   (CLK_HZ),
        .ADDR_W   (11),
        .BASE_ADDR(BASE)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .frame_start(frame_start),
        .set_en     (set_en),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .wr_req     (wr_req),
        .wr_gnt     (wr_gnt),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .sec_tick   (sec_tick)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge vga_clk) begin
        if (wr_req && wr_gnt) begin
            grant_count++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("write_addr", 32'(wr_addr), 32'(mon_exp[18:8]));
                check_output("write_data", 32'(wr_data), 32'(mon_exp[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Holds the given inputs for exactly one clock edge, then releases them.
    task automatic apply_stimulus(input logic fs, input logic se,
                                  input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        frame_start = fs;
        set_en      = se;
        set_hh      = h;
        set_mm      = m;
        set_ss      = s;
        step();
        frame_start = 1'b0;
        set_en      = 1'b0;
    endtask

    task automatic push_string(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) begin
            logic [10:0] a;
            a = BASE + 11'(i);
            exp_q.push_back({a, bytes[63-8*i -: 8]});
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (wr_req === 1'b1 && cycles < 64) begin
            cycles++;
            step();
        end
        check_output("write_done", 32'(wr_req), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int ticks;
        int g0;

        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("reset_wr_req", 32'(wr_req), 32'h0);
        check_output("reset_wr_addr", 32'(wr_addr), 32'(BASE));
        check_output("reset_wr_data", 32'(wr_data), 32'h00);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_sec_tick", 32'(sec_tick), 32'h0);

        // First frame after reset writes 00:00:00 in 8 back-to-back cycles
        push_string(64'h30_30_3A_30_30_3A_30_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check_output("start_latency_req", 32'(wr_req), 32'h1);
        wait_done(cycles);
        check_output("burst_cycles", 32'(cycles), 32'd8);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check_output("clean_frame_req", 32'(wr_req), 32'h0);
        check_output("clean_frame_busy", 32'(busy), 32'h0);
        step();
        check_output("clean_frame_req2", 32'(wr_req), 32'h0);

        // 23:59:59 rolls over to 00:00:00 after one prescaler period
        apply_stimulus(1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
        ticks = 0;
        repeat (CLK_HZ) begin
            step();
            if (sec_tick === 1'b1) ticks++;
        end
        check_output("rollover_ticks", 32'(ticks), 32'd1);
        push_string(64'h30_30_3A_30_30_3A_30_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_done(cycles);

        // Grant stall on index 2 holds address and data
        apply_stimulus(1'b0, 1'b1, 8'h01, 8'h02, 8'h03);
        push_string(64'h30_31_3A_30_32_3A_30_33);
        g0 = grant_count;
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step();
        step();
        wr_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_output("stall_req", 32'(wr_req), 32'h1);
            check_output("stall_addr", 32'(wr_addr), 32'(11'h7FE));
            check_output("stall_data", 32'(wr_data), 32'h3A);
            if (k < 2) step();
        end
        wr_gnt = 1'b1;
        wait_done(cycles);
        check_output("stall_grants", 32'(grant_count - g0), 32'd8);

        // set_en coinciding with a prescaler wrap drops the tick
        apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (CLK_HZ - 1) step();
        apply_stimulus(1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
        check_output("set_wins_sec_tick", 32'(sec_tick), 32'h0);
        push_string(64'h31_32_3A_33_34_3A_35_36);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_done(cycles);

        // Invalid fields load as 00
        apply_stimulus(1'b0, 1'b1, 8'h25, 8'h1A, 8'h30);
        push_string(64'h30_30_3A_30_30_3A_33_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_done(cycles);
        apply_stimulus(1'b0, 1'b1, 8'h19, 8'h60, 8'h0F);
        push_string(64'h31_39_3A_30_30_3A_30_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_done(cycles);

        // A tick mid-burst leaves the snapshot alone and marks the row dirty
        apply_stimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h10);
        repeat (11) step();
        push_string(64'h30_30_3A_30_30_3A_31_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        ticks = 0;
        while (wr_req === 1'b1 && ticks < 64) begin
            ticks++;
            step();
        end
        check_output("tick_burst_cycles", 32'(ticks), 32'd8);
        push_string(64'h30_30_3A_30_30_3A_31_31);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check_output("dirty_after_tick", 32'(wr_req), 32'h1);
        wait_done(cycles);

        // Reset at index 4 aborts; next frame rewrites from index 0
        apply_stimulus(1'b0, 1'b1, 8'h07, 8'h08, 8'h09);
        push_string(64'h30_37_3A_30_00_00_00_00);
        repeat (4) void'(exp_q.pop_back());
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (4) step();
        check_output("abort_addr_idx4", 32'(wr_addr), 32'(11'h000));
        wr_gnt = 1'b0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        wr_gnt = 1'b1;
        check_output("abort_wr_req", 32'(wr_req), 32'h0);
        check_output("abort_busy", 32'(busy), 32'h0);
        check_output("abort_wr_addr", 32'(wr_addr), 32'(BASE));
        check_output("abort_pending", 32'(exp_q.size()), 32'd0);
        push_string(64'h30_30_3A_30_30_3A_30_30);
        apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check_output("rewrite_req", 32'(wr_req), 32'h1);
        wait_done(cycles);
        check_output("rewrite_cycles", 32'(cycles), 32'd8);

        step();
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/text_clock_updater.md
Name: text_clock_updater

Overview:
- Maintains a 24-hour HH:MM:SS time-of-day counter clocked from vga_clk.
- Writes the 8-character ASCII string "HH:MM:SS" into the shared character buffer that the text renderer reads. The buffer is one row of the text region.
- Writes happen only when frame_start signals the start of vertical blank, and only if the time has changed. This keeps the visible frame from tearing.
- Each character write goes through a req/gnt handshake with the character-buffer write-port arbiter.

Parameters:
- CLK_HZ, 25_000_000, vga_clk cycles per second; prescaler modulus.
- ADDR_W, 11, character-buffer address width.
- BASE_ADDR, 11'd0, buffer address of the first character ('H' tens digit).

Ports:
- vga_clk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- set_en  in  1  one-cycle pulse that loads the time.
- set_hh  in  8  BCD hours for set_en.
- set_mm  in  8  BCD minutes for set_en.
- set_ss  in  8  BCD seconds for set_en.
- wr_req  out  1  write request to the buffer arbiter.
- wr_gnt  in  1  arbiter grant; a write completes on a cycle where wr_req && wr_gnt.
- wr_addr  out  ADDR_W  character address.
- wr_data  out  8  ASCII character.
- busy  out  1  high while in the WRITE state.
- sec_tick  out  1  one-cycle pulse when the seconds value advances.

Behaviour:
- Reset values (rst sampled high on an edge):
  - time = 00:00:00, prescaler = 0, dirty = 1, state = IDLE, index = 0.
  - wr_req = 0, wr_addr = BASE_ADDR, wr_data = 8'h00, busy = 0, sec_tick = 0.
  - rst asserted mid-WRITE aborts the sequence immediately. The next frame_start rewrites all 8 characters.
- Prescaler:
  - Counts 0..CLK_HZ-1, then wraps to 0.
  - On the cycle it wraps, sec_tick = 1 and the time advances by one second.
- Time rollover is BCD: SS 59→00 carries into MM; MM 59→00 carries into HH; HH 23→00 with no further carry.
- set_en:
  - Loads set_hh/set_mm/set_ss and clears the prescaler to 0.
  - Takes priority over a tick on the same cycle; that tick is dropped and sec_tick = 0.
  - Invalid inputs load 00 for that field. Invalid means any field > limit (HH 23, MM 59, SS 59) or a BCD nibble > 9.
- dirty flag:
  - Set on any time change (tick or set_en).
  - Cleared when a snapshot is taken.
  - If a change and a snapshot occur on the same cycle, dirty ends up 1.
- FSM states: IDLE, WRITE.
  - IDLE→WRITE: on frame_start && dirty.
    - On that edge, snapshot the current time into an 8-byte string: H1,H0,':',M1,M0,':',S1,S0.
    - Digits are 8'h30 + nibble; ':' is 8'h3A.
    - index = 0, dirty = 0.
  - IDLE with frame_start && !dirty: no action.
  - WRITE outputs:
    - wr_req = 1, busy = 1.
    - wr_addr = BASE_ADDR + index, modulo 2^ADDR_W.
    - wr_data = snapshot[index].
  - WRITE handshake:
    - Outputs are held stable until wr_gnt.
    - On wr_req && wr_gnt with index < 7: index increments and the next character is presented on the following cycle (no idle gap).
    - On grant with index = 7: go to IDLE; wr_req = 0 next cycle.
  - Latency: frame_start → wr_req = 1 is 1 cycle. With wr_gnt tied high, the sequence takes exactly 8 cycles.
  - Events during WRITE:
    - frame_start is ignored.
    - Ticks and set_en update the time and set dirty, but do not alter the snapshot. The new value is written at a later frame_start.
- wr_gnt while wr_req = 0 is ignored.

Test Plan:
- Reset, then frame_start with wr_gnt = 1:
  - wr_req high for 8 consecutive cycles.
  - wr_addr = BASE_ADDR..BASE_ADDR+7.
  - wr_data = 30,30,3A,30,30,3A,30,30.
  - A second frame_start produces no wr_req.
- CLK_HZ = 4; set_en with 23:59:59, then 4 cycles:
  - sec_tick pulses once and time becomes 00:00:00.
  - The next frame_start writes 30,30,3A,30,30,3A,30,30.
- Grant stall: wr_gnt low for 3 cycles on index 2:
  - wr_addr = BASE_ADDR+2 and wr_data = 3A held for those cycles.
  - The sequence completes with 8 grants total.
- set_en on the same cycle as a prescaler wrap, with 12:34:56:
  - time = 12:34:56, sec_tick = 0.
  - The next write sequence is 31,32,3A,33,34,3A,35,36.
- set_en with HH = 8'h25, MM = 8'h1A, SS = 8'h30:
  - Loads 00:00:30 (invalid HH and MM fields load 00).
- Tick during WRITE (written snapshot is 00:00:10):
  - The written bytes are the 00:00:10 values.
  - dirty = 1 afterwards.
  - The next frame_start writes 00:00:11.
- Reset asserted at index 4:
  - wr_req = 0 the next cycle.
  - The next frame_start rewrites all 8 characters from index 0.
